// File: rtl/out_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble) feeding the seven-segment driver.
// One WIDTH-bit value per start, optional two's complement, leading-zero blank flags.
module out_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [WIDTH-1:0]      data,
  output logic                  busy,
  output logic                  valid,
  output logic                  neg,
  output logic [DIGITS*4-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0]    bin_q;
  logic [DIGITS*4-1:0] scr_q;
  logic [CW-1:0]       cnt_q;
  logic                sign_q;

  logic [DIGITS*4-1:0] scr_adj;
  logic [DIGITS*4-1:0] scr_nxt;
  logic [WIDTH-1:0]    bin_nxt;
  logic [WIDTH-1:0]    mag;
  logic                sign_in;
  logic                last;
  logic [DIGITS-1:0]   blank_nxt;
  logic                run;

  assign sign_in = signed_mode & data[WIDTH-1];
  assign mag     = sign_in ? (~data + WIDTH'(1)) : data;
  assign last    = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    scr_adj = scr_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (scr_q[4*d +: 4] >= 4'd5)
        scr_adj[4*d +: 4] = scr_q[4*d +: 4] + 4'd3;
    end
    {scr_nxt, bin_nxt} = {scr_adj[DIGITS*4-2:0], bin_q, 1'b0};
  end

  // Leading-zero scan from the most significant digit down; digit 0 always shown.
  always_comb begin
    blank_nxt = '0;
    run       = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      run          = run & (scr_nxt[4*i +: 4] == 4'd0);
      blank_nxt[i] = run;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = CONVERT;
      CONVERT: if (last)  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    valid = (state == DONE);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bin_q  <= '0;
      scr_q  <= '0;
      cnt_q  <= '0;
      sign_q <= 1'b0;
      bcd    <= '0;
      neg    <= 1'b0;
      blank  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            bin_q  <= mag;
            scr_q  <= '0;
            cnt_q  <= '0;
            sign_q <= sign_in;
          end
        end
        CONVERT: begin
          bin_q <= bin_nxt;
          scr_q <= scr_nxt;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            bcd   <= scr_nxt;
            neg   <= sign_q & (|scr_nxt);
            blank <= blank_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
